// File: rtl/lpc_pkg.sv
// lpc_pkg
// Shared definitions for the LPC analysis front end. The autocorrelation
// accumulator and the autocorrelation control block both import this package
// so that they agree on frame geometry, sample/accumulator widths and the
// handshake state encoding.
//   FRAME_LEN_DEF : samples per analysis frame
//   ORDER_DEF     : highest autocorrelation lag (lags 0..ORDER)
//   DW_DEF        : signed sample width
//   ACCW_DEF      : signed accumulator / result width
//   LAG_W         : width of every lag field on the interfaces
//   CNT_W         : width of the per-lag beat counter
package lpc_pkg;

  localparam int FRAME_LEN_DEF = 256;
  localparam int ORDER_DEF     = 10;
  localparam int DW_DEF        = 16;
  localparam int ACCW_DEF      = 40;
  localparam int LAG_W         = 11;
  localparam int CNT_W         = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } lpcState_e;

  // Number of beats that make up lag 'lag' of a frame: x[n]*x[n-lag] only
  // exists for n = lag .. frameLen-1.
  function automatic logic [CNT_W-1:0] beatsForLag(input int frameLen,
                                                    input logic [LAG_W-1:0] lag);
    return CNT_W'(frameLen) - CNT_W'(lag);
  endfunction

endpackage

// File: rtl/autocorrelation_mac.sv
// autocorrelation_mac
// Two-stage multiply-accumulate used by the autocorrelation accumulator.
// Stage 1 registers the full-precision signed product of the two operands;
// stage 2 sign-extends that product and adds it to the running sum.
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   clear_i  : synchronous clear of the product stage and the sum
//   enable_i : operands are valid this cycle and must be accumulated
//   a_i, b_i : signed operands
//   sum_o    : running signed sum
module autocorrelation_mac
  import lpc_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int ACCW = ACCW_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear_i,
  input  logic                   enable_i,
  input  logic signed [DW-1:0]   a_i,
  input  logic signed [DW-1:0]   b_i,
  output logic signed [ACCW-1:0] sum_o
);

  localparam int PW  = 2 * DW;
  localparam int EXT = ACCW - PW;

  logic signed [PW-1:0]   product_q;
  logic                   productValid_q;
  logic signed [ACCW-1:0] sum_q;
  logic        [ACCW-1:0] productExt;

  // The product is sign-extended, never saturated: the accumulator is sized so
  // that a whole frame of full-scale products cannot overflow it.
  assign productExt = {{EXT{product_q[PW-1]}}, product_q};

  // Product register and accumulator. A clear drops any product still in
  // flight as well as the sum, so the next lag starts from exactly zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      product_q      <= '0;
      productValid_q <= 1'b0;
      sum_q          <= '0;
    end else if (clear_i) begin
      product_q      <= '0;
      productValid_q <= 1'b0;
      sum_q          <= '0;
    end else begin
      productValid_q <= enable_i;
      if (enable_i) begin
        product_q <= a_i * b_i;
      end
      if (productValid_q) begin
        sum_q <= sum_q + $signed(productExt);
      end
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/autocorrelation_accumulator.sv
// autocorrelation_accumulator
// Computes r[lag] = sum over n of x[n]*x[n-lag] for lags 0..ORDER of one
// frame. Beats arrive already paired (x[n], x[n-lag]) and tagged with their
// lag; each lag is closed by in_last and its result is offered on a
// valid/ready result port before the next lag is accepted.
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   start    : one-cycle pulse starting a frame (ignored unless idle)
//   x_n      : sample x[n]
//   x_nk     : sample x[n-lag]
//   in_lag   : lag tagging the beat
//   in_valid : beat valid
//   in_last  : final beat of the current lag
//   in_ready : beat accepted when in_valid and in_ready are both high
//   r_data   : result r[lag]
//   r_lag    : lag of r_data
//   r_valid  : result valid
//   r_ready  : result consumed when r_valid and r_ready are both high
//   done     : one-cycle pulse after the r[ORDER] handshake
//   err      : sticky protocol error (wrong lag tag or wrong beat count)
module autocorrelation_accumulator
  import lpc_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int ORDER     = ORDER_DEF,
  parameter int DW        = DW_DEF,
  parameter int ACCW      = ACCW_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic signed [DW-1:0]   x_n,
  input  logic signed [DW-1:0]   x_nk,
  input  logic [LAG_W-1:0]       in_lag,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic signed [ACCW-1:0] r_data,
  output logic [LAG_W-1:0]       r_lag,
  output logic                   r_valid,
  input  logic                   r_ready,
  output logic                   done,
  output logic                   err
);

  lpcState_e              state_q, state_d;
  logic [LAG_W-1:0]       expLag_q;
  logic [CNT_W-1:0]       beatCnt_q;
  logic [CNT_W-1:0]       beatCntNext;
  logic                   drainCnt_q;
  logic                   err_q;
  logic                   done_q;
  logic                   rValid_q;
  logic signed [ACCW-1:0] rData_q;
  logic [LAG_W-1:0]       rLag_q;
  logic signed [ACCW-1:0] macSum;

  logic frameStart;
  logic beatAccept;
  logic resultTaken;
  logic finalLag;
  logic macClear;
  logic lagMismatch;
  logic countMismatch;

  // Handshake qualifiers shared by the state machine and the datapath.
  // Clearing the MAC on every handshake is safe because no beat can be in
  // flight once the result is sitting in HOLD.
  assign frameStart    = (state_q == IDLE) && start;
  assign beatAccept    = (state_q == ACCUM) && in_valid;
  assign resultTaken   = (state_q == HOLD) && rValid_q && r_ready;
  assign finalLag      = (rLag_q == LAG_W'(ORDER));
  assign macClear      = frameStart || resultTaken;
  assign beatCntNext   = beatCnt_q + CNT_W'(1);
  assign lagMismatch   = (in_lag != expLag_q);
  assign countMismatch = in_last && (beatCntNext != beatsForLag(FRAME_LEN, expLag_q));

  autocorrelation_mac #(
    .DW  (DW),
    .ACCW(ACCW)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .clear_i (macClear),
    .enable_i(beatAccept),
    .a_i     (x_n),
    .b_i     (x_nk),
    .sum_o   (macSum)
  );

  // Next-state logic. DRAIN lasts two cycles so the final product has left
  // the multiply register and landed in the sum before HOLD captures it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = ACCUM;
      ACCUM: if (in_valid && in_last) state_d = DRAIN;
      DRAIN: if (drainCnt_q) state_d = HOLD;
      HOLD:  if (rValid_q && r_ready) state_d = finalLag ? IDLE : ACCUM;
      default: state_d = IDLE;
    endcase
  end

  // State register; a reset anywhere in a frame simply drops it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Lag bookkeeping: expected lag, beats seen in this lag, drain timer and the
  // sticky error flag. The error is only reported; processing carries on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      expLag_q   <= '0;
      beatCnt_q  <= '0;
      drainCnt_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      drainCnt_q <= (state_q == DRAIN) ? ~drainCnt_q : 1'b0;
      if (frameStart) begin
        expLag_q  <= '0;
        beatCnt_q <= '0;
        err_q     <= 1'b0;
      end else if (resultTaken) begin
        beatCnt_q <= '0;
        if (!finalLag) begin
          expLag_q <= expLag_q + LAG_W'(1);
        end
      end else if (beatAccept) begin
        beatCnt_q <= beatCntNext;
        if (lagMismatch || countMismatch) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  // Result port. The first HOLD cycle latches the finished sum, so r_valid
  // rises three cycles after the last beat is accepted; the registers then
  // stay frozen until the consumer takes the result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rValid_q <= 1'b0;
      rData_q  <= '0;
      rLag_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= resultTaken && finalLag;
      if (resultTaken) begin
        rValid_q <= 1'b0;
      end else if ((state_q == HOLD) && !rValid_q) begin
        rValid_q <= 1'b1;
        rData_q  <= macSum;
        rLag_q   <= expLag_q;
      end
    end
  end

  assign in_ready = (state_q == ACCUM);
  assign r_valid  = rValid_q;
  assign r_data   = rData_q;
  assign r_lag    = rLag_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_autocorrelation_accumulator.sv
// tb_autocorrelation_accumulator
// Scoreboard bench: the frame driver computes each r[lag] from its own sample
// array while sending the beats and queues it; the result monitor pops and
// compares on every result handshake.
module tb_autocorrelation_accumulator;

  localparam int FRAME_LEN = 256;
  localparam int ORDER     = 10;
  localparam int DW        = 16;
  localparam int ACCW      = 40;

  typedef struct {
    int               lag;
    logic [ACCW-1:0]  data;
  } expRes_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic signed [DW-1:0]   x_n;
  logic signed [DW-1:0]   x_nk;
  logic [10:0]            in_lag;
  logic                   in_valid;
  logic                   in_last;
  logic                   in_ready;
  logic signed [ACCW-1:0] r_data;
  logic [10:0]            r_lag;
  logic                   r_valid;
  logic                   r_ready;
  logic                   done;
  logic                   err;

  logic signed [DW-1:0] smp [0:FRAME_LEN-1];
  expRes_t              expQ [$];
  int                   checks   = 0;
  int                   failures = 0;
  int                   stallLag = -1;

  autocorrelation_accumulator #(
    .FRAME_LEN(FRAME_LEN),
    .ORDER    (ORDER),
    .DW       (DW),
    .ACCW     (ACCW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .x_n     (x_n),
    .x_nk    (x_nk),
    .in_lag  (in_lag),
    .in_valid(in_valid),
    .in_last (in_last),
    .in_ready(in_ready),
    .r_data  (r_data),
    .r_lag   (r_lag),
    .r_valid (r_valid),
    .r_ready (r_ready),
    .done    (done),
    .err     (err)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Offer one beat and hold it until the DUT accepts it (bounded wait).
  task automatic applyStimulus(input logic signed [DW-1:0] a,
                               input logic signed [DW-1:0] b,
                               input int lag, input logic last);
    int waitCycles;
    waitCycles = 0;
    @(negedge clk);
    x_n      = a;
    x_nk     = b;
    in_lag   = 11'(lag);
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) checkOutput("beat_accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Drive one frame lag by lag, queueing the expected r[lag] of every lag that
  // is completed. badLag tags the first beat of that lag with lag+1,
  // shortBeats truncates lag 0, abortLag pulses reset in the middle of that
  // lag, glitchLag pulses start mid-lag (must be ignored).
  task automatic runFrame(input int badLag, input int shortBeats, input int abortLag,
                          input int glitchLag, input logic expectErr);
    longint acc;
    int     nBeats;
    int     cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("err_cleared_by_start", 64'(err), 64'd0);
    for (int lag = 0; lag <= ORDER; lag++) begin
      nBeats = FRAME_LEN - lag;
      if (lag == 0 && shortBeats > 0) nBeats = shortBeats;
      acc = 0;
      for (int i = 0; i < nBeats; i++) begin
        if (lag == abortLag && i == 100) begin
          @(negedge clk);
          in_valid = 1'b0;
          reset    = 1'b0;
          @(negedge clk);
          checkOutput("abort_in_ready", 64'(in_ready), 64'd0);
          checkOutput("abort_r_valid", 64'(r_valid), 64'd0);
          checkOutput("abort_r_data", 64'($unsigned(r_data)), 64'd0);
          checkOutput("abort_r_lag", 64'(r_lag), 64'd0);
          checkOutput("abort_done", 64'(done), 64'd0);
          checkOutput("abort_err", 64'(err), 64'd0);
          @(negedge clk);
          reset = 1'b1;
          checkOutput("abort_no_pending", 64'(expQ.size()), 64'd0);
          return;
        end
        acc += longint'(smp[lag + i]) * longint'(smp[i]);
        if (i == nBeats - 1) expQ.push_back('{lag, ACCW'(acc)});
        if (lag == glitchLag && i == 10) start = 1'b1;
        applyStimulus(smp[lag + i], smp[i], (lag == badLag && i == 0) ? lag + 1 : lag,
                      i == nBeats - 1);
        start = 1'b0;
        if (lag == badLag && i == 0) checkOutput("err_on_bad_lag", 64'(err), 64'd1);
      end
      @(negedge clk);
      cnt = 1;
      checkOutput("drain_in_ready", 64'(in_ready), 64'd0);
      while (!r_valid && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      checkOutput("r_valid_latency", 64'(cnt), 64'd4);
    end
    checkOutput("err_at_frame_end", 64'(err), 64'(expectErr));
  endtask

  // Wait for the monitor to retire every queued result, then idle a little.
  task automatic waitDrain();
    int cnt;
    cnt = 0;
    while (expQ.size() != 0 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("results_drained", 64'(expQ.size()), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  // Result monitor: optionally stalls one lag for 20 cycles checking that the
  // result stays frozen, then compares every handshake against the queue.
  initial begin
    expRes_t          exp;
    logic [ACCW-1:0]  heldData;
    logic [10:0]      heldLag;
    forever begin
      @(negedge clk);
      if (reset && r_valid) begin
        if (stallLag >= 0 && int'(r_lag) == stallLag) begin
          r_ready  = 1'b0;
          heldData = r_data;
          heldLag  = r_lag;
          repeat (20) begin
            @(negedge clk);
            checkOutput("stall_r_valid", 64'(r_valid), 64'd1);
            checkOutput("stall_r_data", 64'($unsigned(r_data)), 64'(heldData));
            checkOutput("stall_r_lag", 64'(r_lag), 64'(heldLag));
            checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
          end
          r_ready  = 1'b1;
          stallLag = -1;
        end
        if (expQ.size() == 0) begin
          checkOutput("unexpected_result", 64'(r_lag), 64'hFFFF);
        end else begin
          exp = expQ.pop_front();
          checkOutput("r_lag", 64'(r_lag), 64'(exp.lag));
          checkOutput("r_data", 64'($unsigned(r_data)), 64'(exp.data));
          if (exp.lag == ORDER) begin
            @(negedge clk);
            checkOutput("done_pulse", 64'(done), 64'd1);
            @(negedge clk);
            checkOutput("done_single_cycle", 64'(done), 64'd0);
          end
        end
      end
    end
  end

  // Main sequence of frames.
  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    x_n      = '0;
    x_nk     = '0;
    in_lag   = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    r_ready  = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
    checkOutput("reset_r_valid", 64'(r_valid), 64'd0);
    checkOutput("reset_r_data", 64'($unsigned(r_data)), 64'd0);
    checkOutput("reset_r_lag", 64'(r_lag), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_err", 64'(err), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Constant frame, r[k] = 10000*(256-k); consumer stalls at lag 3.
    for (int i = 0; i < FRAME_LEN; i++) smp[i] = 16'sd100;
    stallLag = 3;
    runFrame(-1, 0, -1, -1, 1'b0);
    waitDrain();
    checkOutput("const_r10_value", 64'($unsigned(r_data)), 64'd2460000);

    // Full-scale negative frame, r[0] = 256 * 2^30 with no overflow.
    for (int i = 0; i < FRAME_LEN; i++) smp[i] = -16'sd32768;
    runFrame(-1, 0, -1, -1, 1'b0);
    waitDrain();

    // Random frame with a wrong lag tag at lag 4: err sticks, results still flow.
    for (int i = 0; i < FRAME_LEN; i++) smp[i] = DW'($urandom_range(0, 65535));
    runFrame(4, 0, -1, -1, 1'b1);
    waitDrain();

    // Random frame aborted by reset during lag 6.
    for (int i = 0; i < FRAME_LEN; i++) smp[i] = DW'($urandom_range(0, 65535));
    runFrame(-1, 0, 6, -1, 1'b0);
    repeat (3) @(negedge clk);

    // Fresh full frame after the abort, with a stray start pulse mid-lag 2.
    for (int i = 0; i < FRAME_LEN; i++) smp[i] = DW'($urandom_range(0, 65535));
    runFrame(-1, 0, -1, 2, 1'b0);
    waitDrain();

    // Lag 0 closed after 250 beats: err set, result is the 250-product sum.
    for (int i = 0; i < FRAME_LEN; i++) smp[i] = DW'($urandom_range(0, 65535));
    runFrame(-1, 250, -1, -1, 1'b1);
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
